// File: rtl/irq_ctrl.sv
// Interrupt controller on the picorv32 native bus: pending/enable registers, edge/level
// sources, registered irq vector. Define IRQC_SYNC_EN for a 2-flop input synchroniser.
module irq_ctrl #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] EDGE_MASK = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               irqc_sel,
  input  logic [3:0]         addr,
  input  logic [3:0]         wstrb,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               ready,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        eoi,
  output logic [31:0]        irq_out
);

  localparam logic [31:0] VALID = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'h1 << NUM_SRC) - 32'h1);

  typedef enum logic [1:0] {IDLE, RESP, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] pending, enable, src_q;
  logic [31:0] src_ext, src_s;
  logic [31:0] byte_mask, rd_val;
  logic [31:0] w1c, force_set, set_v, clr_v;
  logic        wr, en_wr;
  logic        unused_addr;

  assign unused_addr = ^addr[1:0];

  always_comb begin
    src_ext = '0;
    src_ext[NUM_SRC-1:0] = irq_src;
  end

`ifdef IRQC_SYNC_EN
  logic [31:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src_ext;
      sync2 <= sync1;
    end
  end
  assign src_s = sync2;
`else
  assign src_s = src_ext;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (irqc_sel) state_nx = RESP;
      RESP:    state_nx = DONE;
      DONE:    if (!irqc_sel) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ready     = (state == RESP);
  assign wr        = ready && (wstrb != 4'h0);
  assign byte_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign en_wr     = wr && (addr[3:2] == 2'd1);
  assign w1c       = (wr && addr[3:2] == 2'd0) ? (data_i & byte_mask) : 32'h0;
  assign force_set = (wr && addr[3:2] == 2'd3) ? (data_i & byte_mask) : 32'h0;

  always_comb begin
    rd_val = 32'h0;
    case (addr[3:2])
      2'd0:    rd_val = pending;
      2'd1:    rd_val = enable;
      2'd2:    rd_val = pending & enable;
      default: rd_val = 32'h0;
    endcase
  end

  assign data_o = ready ? rd_val : 32'h0;

  // Sets are OR-ed in after clears so any set wins over a same-cycle clear.
  assign set_v = ((src_s & ~src_q) & EDGE_MASK) | (src_s & ~EDGE_MASK) | force_set;
  assign clr_v = w1c | eoi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      enable  <= '0;
      src_q   <= '0;
      irq_out <= '0;
    end else begin
      state   <= state_nx;
      src_q   <= src_s;
      pending <= ((pending & ~clr_v) | set_v) & VALID;
      if (en_wr) enable <= ((enable & ~byte_mask) | (data_i & byte_mask)) & VALID;
      irq_out <= pending & enable;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl (default build, NUM_SRC=8, source 2 level-type).
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        irqc_sel;
  logic [3:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ready;
  logic [7:0]  irq_src;
  logic [31:0] eoi;
  logic [31:0] irq_out;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb[$];

  irq_ctrl #(.NUM_SRC(8), .EDGE_MASK(32'hFFFF_FFFB)) dut (
    .clk(clk), .reset(reset), .irqc_sel(irqc_sel), .addr(addr), .wstrb(wstrb),
    .data_i(data_i), .data_o(data_o), .ready(ready), .irq_src(irq_src),
    .eoi(eoi), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bus access; reads push their expected data and pop it when ready shows up.
  // commit_src is applied so it is sampled on the same edge the access commits.
  task automatic bus(input logic [3:0] a, input logic [3:0] ws, input logic [31:0] d,
                     input logic [31:0] exp, input bit use_src = 1'b0,
                     input logic [7:0] commit_src = 8'h0, input bit rst_resp = 1'b0);
    int lat;
    logic [31:0] e;
    @(negedge clk);
    irqc_sel = 1'b1; addr = a; wstrb = ws; data_i = d;
    if (ws == 4'h0) sb.push_back(exp);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 5);
    if (!ready) begin
      chk("ready_timeout", 32'(ready), 32'h1);
      if (sb.size() > 0) e = sb.pop_front();
    end else begin
      chk("latency", 32'(lat), 32'h1);
      if (ws == 4'h0) begin
        e = sb.pop_front();
        chk("rdata", data_o, e);
      end
      if (use_src) irq_src = commit_src;
      if (rst_resp) reset = 1'b1;
    end
    @(negedge clk);
    chk("ready_one_cycle", 32'(ready), 32'h0);
    irqc_sel = 1'b0; wstrb = 4'h0; reset = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    bus(a, 4'h0, 32'h0, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] ws, input logic [31:0] d);
    bus(a, ws, d, 32'h0);
  endtask

  initial begin
    reset = 1'b1; irqc_sel = 1'b0; addr = 4'h0; wstrb = 4'h0; data_i = 32'h0;
    irq_src = 8'h0; eoi = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_irq_out", irq_out, 32'h0);
    reset = 1'b0;

    // reset values of all registers
    rd(4'h0, 32'h0); rd(4'h4, 32'h0); rd(4'h8, 32'h0); rd(4'hC, 32'h0);

    // edge pulse on source 0
    wr(4'h4, 4'hF, 32'h0000_0003);
    @(negedge clk); irq_src = 8'h01;
    @(negedge clk); irq_src = 8'h00;
    chk("irq_out_before", irq_out, 32'h0);
    @(negedge clk);
    chk("irq_out_edge", irq_out, 32'h1);
    rd(4'h0, 32'h1);
    rd(4'h8, 32'h1);

    // eoi clear
    @(negedge clk); eoi = 32'h1;
    @(negedge clk); eoi = 32'h0;
    @(negedge clk);
    chk("irq_out_eoi", irq_out, 32'h0);
    rd(4'h0, 32'h0);

    // W1C clear
    @(negedge clk); irq_src = 8'h01;
    @(negedge clk); irq_src = 8'h00;
    @(negedge clk);
    chk("irq_out_edge2", irq_out, 32'h1);
    wr(4'h0, 4'hF, 32'h1);
    @(negedge clk);
    chk("irq_out_w1c", irq_out, 32'h0);
    rd(4'h0, 32'h0);

    // held-high edge source does not re-trigger after clear
    @(negedge clk); irq_src = 8'h01;
    repeat (2) @(negedge clk);
    wr(4'h0, 4'hF, 32'h1);
    repeat (10) @(negedge clk);
    rd(4'h0, 32'h0);
    chk("irq_out_held", irq_out, 32'h0);
    irq_src = 8'h00;

    // edge on source 1 in the same cycle as its W1C: set wins
    bus(4'h0, 4'hF, 32'h2, 32'h0, 1'b1, 8'h02);
    irq_src = 8'h00;
    rd(4'h0, 32'h2);
    chk("irq_out_setwins", irq_out, 32'h2);
    wr(4'h0, 4'hF, 32'h2);
    rd(4'h0, 32'h0);

    // level source 2: clear ignored while high
    @(negedge clk); irq_src = 8'h04;
    repeat (2) @(negedge clk);
    wr(4'h0, 4'hF, 32'h4);
    rd(4'h0, 32'h4);
    irq_src = 8'h00;
    @(negedge clk);
    wr(4'h0, 4'hF, 32'h4);
    rd(4'h0, 32'h0);

    // enabling an already-pending bit, then disabling keeps pending
    wr(4'hC, 4'h1, 32'h4);
    rd(4'h0, 32'h4);
    chk("irq_out_masked", irq_out, 32'h0);
    wr(4'h4, 4'hF, 32'h7);
    @(negedge clk);
    chk("irq_out_enable", irq_out, 32'h4);
    wr(4'h4, 4'hF, 32'h3);
    @(negedge clk);
    chk("irq_out_disable", irq_out, 32'h0);
    rd(4'h0, 32'h4);
    rd(4'h8, 32'h0);
    wr(4'h0, 4'hF, 32'h4);

    // FORCE with byte lanes, bits above NUM_SRC ignored
    wr(4'hC, 4'b0001, 32'hFFFF_FFFF);
    rd(4'h0, 32'h0000_00FF);
    wr(4'hC, 4'b0010, 32'hFFFF_FFFF);
    rd(4'h0, 32'h0000_00FF);
    wr(4'h4, 4'hF, 32'hFFFF_FFFF);
    rd(4'h4, 32'h0000_00FF);
    rd(4'h8, 32'h0000_00FF);
    rd(4'hC, 32'h0);
    @(negedge clk);
    chk("irq_out_all", irq_out, 32'h0000_00FF);

    // reset during RESP
    bus(4'h0, 4'h0, 32'h0, 32'h0000_00FF, 1'b0, 8'h0, 1'b1);
    rd(4'h0, 32'h0);
    rd(4'h4, 32'h0);
    chk("irq_out_after_rst", irq_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Memory-mapped interrupt controller on the picorv32 native bus. It sits directly upstream of the core's irq input. It collects NUM_SRC peripheral interrupt lines (UART, countdown timer, future blocks), latches them into a pending register and masks them with an enable register. It drives the registered 32-bit irq vector into the cpu and consumes the cpu's eoi vector to retire edge interrupts.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..32); vector bits at and above NUM_SRC are tied to 0.
EDGE_MASK, 32'hFFFF_FFFF, per-source type: 1 = rising-edge latched, 0 = level.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
irqc_sel  input  1  bus select (mem_valid qualified by address decode)
addr  input  4  byte address within block; addr[3:2] selects register
wstrb  input  4  byte write strobes; nonzero = write, zero = read
data_i  input  32  write data
data_o  output  32  read data, valid while ready=1
ready  output  1  one-cycle access acknowledge
irq_src  input  NUM_SRC  peripheral interrupt requests, active high
eoi  input  32  end-of-interrupt vector from cpu
irq_out  output  32  registered interrupt vector to cpu irq

Behaviour:
- Reset (reset=1 at a clk edge): pending=0, enable=0, src_q=0, irq_out=0, ready=0, data_o=0, FSM=IDLE. Reset mid-access drops ready and abandons the access with no register write.
- Register map:
  - 0x0 PENDING: read; write-1-to-clear.
  - 0x4 ENABLE: read/write.
  - 0x8 STATUS: read-only, pending & enable.
  - 0xC FORCE: write-1-to-set pending; reads 0.
- Byte lanes: wstrb[i] gates data_i[8i+7:8i] for ENABLE, PENDING-clear and FORCE. Bits >= NUM_SRC read 0 and ignore writes.
- Bus FSM:
  - IDLE: irqc_sel=1 → RESP.
  - RESP: ready=1 for exactly one cycle; data_o = selected register; the write commits at this clk edge; go to DONE.
  - DONE: ready=0; stay until irqc_sel=0, then IDLE.
  - Read latency is 1 cycle after sel. No back-to-back acceptance without sel dropping for at least one cycle.
- Edge sources (EDGE_MASK[i]=1):
  - src_q registers irq_src each cycle.
  - Edge = src & ~src_q sets pending[i] at the same clk edge where it is detected.
  - Cleared by PENDING W1C or by eoi[i]=1.
  - A held-high source does not re-trigger.
- Level sources (EDGE_MASK[i]=0): pending[i] is set every cycle irq_src[i]=1. A clear only takes effect once the source has dropped.
- Simultaneous events on one bit in one cycle: set (edge, level, or FORCE) wins over clear (W1C or eoi).
- irq_out = registered (pending & enable): one cycle after pending changes. Total latency is 1 cycle from the sampled source edge to irq_out, without the synchroniser.
- Enabling a bit that is already pending raises irq_out the cycle after the ENABLE write commits. Disabling lowers it one cycle after, but pending is kept.

Optional Feature:
IRQC_SYNC_EN:
- Defined: irq_src passes through a 2-flop synchroniser (reset 0) before edge/level logic. This adds 2 cycles of latency and makes asynchronous sources safe.
- Undefined: irq_src is used directly and must be synchronous to clk.
- Register map and bus timing are identical in both cases.

Test Plan:
1. Reset, then read 0x0/0x4/0x8/0xC → all return 32'h0, ready high exactly 1 cycle after sel, irq_out=0.
2. Write ENABLE=32'h0000_0003; pulse irq_src[0] for 1 cycle → PENDING reads 32'h1. irq_out[0] rises 1 cycle after the sampled edge (3 with IRQC_SYNC_EN). Hold irq_src[0] high 10 cycles → no re-trigger after a clear.
3. With pending[0]=1, drive eoi[0]=1 for one cycle → PENDING=0 and irq_out[0]=0 on the next cycle. Repeat using a W1C write of 32'h1 to 0x0 → same result.
4. Same cycle: edge on irq_src[1] and W1C 32'h2 to 0x0 → pending[1] stays 1.
5. NUM_SRC=8, EDGE_MASK[2]=0: hold irq_src[2] high and write W1C 32'h4 → PENDING still reads 32'h4. Drop the source, W1C again → PENDING=0.
6. Write FORCE 32'hFFFF_FFFF with wstrb=4'b0001 → PENDING=32'h0000_00FF. Assert reset during a RESP cycle → ready=0 and all registers return to 0 next cycle.
